// File: rtl/smem_recirc_queue.sv
// Recirculation queue: pairs in-flight contexts with DRAM responses, injects fresh reads.
// Latency: entering word is FIFO-visible after QLAT+1 cycles, on the outputs after QLAT+2.
// Backpressure: stall freezes output pops and fresh-read injection; pushes never stall and drop on full.
module smem_recirc_queue #(
    parameter int CTX_W     = 290,
    parameter int DEPTH     = 256,
    parameter int MEM_W     = 768,
    parameter int MEM_DEPTH = 32,
    parameter int QLAT      = 3
) (
    input  logic                         Clk_32UI,
    input  logic                         reset_n,
    input  logic                         stall,
    input  logic [5:0]                   in_status,
    input  logic [CTX_W-1:0]             in_ctx,
    output logic [7:0]                   query_position_2RAM,
    input  logic [7:0]                   in_qpos,
    input  logic [7:0]                   new_read_query_2Queue,
    input  logic                         DRAM_get,
    input  logic [MEM_W-1:0]             mem_data,
    input  logic                         new_read_valid,
    input  logic [CTX_W-1:0]             new_ctx,
    input  logic                         load_done,
    output logic                         new_read,
    output logic [5:0]                   status_out,
    output logic [CTX_W-1:0]             ctx_out,
    output logic [7:0]                   query_out,
    output logic [MEM_W-1:0]             mem_out,
    output logic [$clog2(DEPTH):0]       ctx_count,
    output logic [$clog2(MEM_DEPTH):0]   mem_count,
    output logic                         ctx_overflow,
    output logic                         mem_overflow,
    output logic                         done
);
    localparam logic [5:0] F_INIT  = 6'd0;
    localparam logic [5:0] F_BREAK = 6'd2;
    localparam logic [5:0] BUBBLE  = 6'h30;
    // Context layout, LSB first: min_intv[6:0], forward_i[13:7], then read_num/ptr_curr/ik_* above.
    localparam int MIN_LSB = 0;
    localparam int MIN_W   = 7;
    localparam int FWD_LSB = 7;
    localparam int FWD_W   = 7;
    localparam int CW      = 6 + CTX_W + 8;

    typedef enum logic [1:0] {S_FILL, S_RUN, S_DRAIN, S_DONE} state_e;

    logic [5:0]       pst_q  [QLAT];
    logic [CTX_W-1:0] pctx_q [QLAT];
    logic             pipe_busy;
    logic             ctx_push, ctx_pop, mem_pop;
    logic [CW-1:0]    ctx_head;
    logic [MEM_W-1:0] mem_head;
    logic [5:0]       head_st;
    logic             ctx_nempty, mem_nempty, rule_brk, rule_pair;
    logic [FWD_W-1:0] fwd_inc;
    logic [CTX_W-1:0] nctx;
    logic [5:0]       status_q, status_d;
    logic [CTX_W-1:0] ctx_q, ctx_d;
    logic [7:0]       query_q, query_d;
    logic [MEM_W-1:0] mem_q, mem_d;
    state_e           state_q;
    logic             done_q;

    assign query_position_2RAM = in_qpos;

    // Delay pipe runs regardless of stall so the query byte lines up with its word.
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QLAT; i++) begin
                pst_q[i]  <= BUBBLE;
                pctx_q[i] <= '0;
            end
        end else begin
            pst_q[0]  <= in_status;
            pctx_q[0] <= in_ctx;
            for (int i = 1; i < QLAT; i++) begin
                pst_q[i]  <= pst_q[i-1];
                pctx_q[i] <= pctx_q[i-1];
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < QLAT; i++) pipe_busy = pipe_busy | (pst_q[i] < 6'd3);
    end

    assign ctx_push = pst_q[QLAT-1] < 6'd3;

    fifo #(.W(CW), .DEPTH(DEPTH)) u_ctx_fifo (
        .clk_i(Clk_32UI), .arst_n_i(reset_n),
        .wr_vld_i(ctx_push), .wr_dat_i({pst_q[QLAT-1], pctx_q[QLAT-1], new_read_query_2Queue}),
        .rd_rdy_i(ctx_pop), .rd_dat_o(ctx_head),
        .count_o(ctx_count), .ovf_o(ctx_overflow)
    );

    fifo #(.W(MEM_W), .DEPTH(MEM_DEPTH)) u_mem_fifo (
        .clk_i(Clk_32UI), .arst_n_i(reset_n),
        .wr_vld_i(DRAM_get), .wr_dat_i(mem_data),
        .rd_rdy_i(mem_pop), .rd_dat_o(mem_head),
        .count_o(mem_count), .ovf_o(mem_overflow)
    );

    assign head_st    = ctx_head[CW-1 -: 6];
    assign ctx_nempty = ctx_count != '0;
    assign mem_nempty = mem_count != '0;
    assign rule_brk   = !stall && ctx_nempty && (head_st == F_BREAK);
    assign rule_pair  = !stall && !rule_brk && ctx_nempty && mem_nempty;
    assign ctx_pop    = rule_brk || rule_pair;
    assign mem_pop    = rule_pair;
    assign new_read   = reset_n && !stall && !ctx_pop && (state_q != S_DRAIN) && new_read_valid;

    always_comb begin
        fwd_inc = new_ctx[FWD_LSB +: FWD_W] + FWD_W'(1);
        nctx = new_ctx;
        nctx[FWD_LSB +: FWD_W] = fwd_inc;
        nctx[MIN_LSB +: MIN_W] = MIN_W'(1);
    end

    always_comb begin
        status_d = status_q;
        ctx_d    = ctx_q;
        query_d  = query_q;
        mem_d    = mem_q;
        if (!stall) begin
            status_d = BUBBLE;
            ctx_d    = '1;
            query_d  = '1;
            mem_d    = '1;
            if (ctx_pop) begin
                status_d = head_st;
                ctx_d    = ctx_head[CTX_W+7:8];
                query_d  = ctx_head[7:0];
                if (rule_pair) mem_d = mem_head;
            end else if (new_read) begin
                status_d = F_INIT;
                ctx_d    = nctx;
                query_d  = 8'd0;
            end
        end
    end

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= BUBBLE;
            ctx_q    <= '1;
            query_q  <= '1;
            mem_q    <= '1;
        end else begin
            status_q <= status_d;
            ctx_q    <= ctx_d;
            query_q  <= query_d;
            mem_q    <= mem_d;
        end
    end

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FILL;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FILL:  if (new_read) state_q <= S_RUN;
                S_RUN:   if (load_done && !new_read_valid) state_q <= S_DRAIN;
                S_DRAIN: if (!pipe_busy && !ctx_nempty && !mem_nempty) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE:  state_q <= S_DONE;
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign status_out = status_q;
    assign ctx_out    = ctx_q;
    assign query_out  = query_q;
    assign mem_out    = mem_q;
    assign done       = done_q;
endmodule

// Generic circular FIFO with exact occupancy and a sticky drop flag.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none upstream; a push to a full FIFO without a same-cycle pop is dropped.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      wr_vld_i,
    input  logic [W-1:0]              wr_dat_i,
    input  logic                      rd_rdy_i,
    output logic [W-1:0]              rd_dat_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  ram_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, full, wr_acc;

    assign full   = cnt_q == (AW+1)'(DEPTH);
    assign wr_acc = wr_vld_i && (!full || rd_rdy_i);
    assign cnt_d  = cnt_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_rdy_i};

    always_ff @(posedge clk_i) begin
        if (wr_acc) ram_q[wr_ptr_q] <= wr_dat_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_rdy_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            if (wr_vld_i && !wr_acc) ovf_q <= 1'b1;
        end
    end

    assign rd_dat_o = ram_q[rd_ptr_q];
    assign count_o  = cnt_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_smem_recirc_queue.sv
// Directed bench for smem_recirc_queue: stimulus queues expected output words, a monitor pops and compares them.
module tb_smem_recirc_queue;
    localparam int CTX_W = 290;
    localparam int DEPTH = 256;
    localparam int MEM_W = 768;
    localparam int MEM_DEPTH = 32;
    localparam int QLAT = 3;
    localparam logic [5:0] BUBBLE = 6'h30;

    logic               Clk_32UI = 1'b0;
    logic               reset_n, stall, DRAM_get, new_read_valid, load_done;
    logic [5:0]         in_status;
    logic [CTX_W-1:0]   in_ctx, new_ctx;
    logic [7:0]         in_qpos, new_read_query_2Queue, query_position_2RAM;
    logic [MEM_W-1:0]   mem_data;
    logic               new_read, ctx_overflow, mem_overflow, done;
    logic [5:0]         status_out;
    logic [CTX_W-1:0]   ctx_out;
    logic [7:0]         query_out;
    logic [MEM_W-1:0]   mem_out;
    logic [8:0]         ctx_count;
    logic [5:0]         mem_count;

    smem_recirc_queue #(.CTX_W(CTX_W), .DEPTH(DEPTH), .MEM_W(MEM_W), .MEM_DEPTH(MEM_DEPTH), .QLAT(QLAT)) dut (
        .Clk_32UI(Clk_32UI), .reset_n(reset_n), .stall(stall),
        .in_status(in_status), .in_ctx(in_ctx),
        .query_position_2RAM(query_position_2RAM), .in_qpos(in_qpos),
        .new_read_query_2Queue(new_read_query_2Queue),
        .DRAM_get(DRAM_get), .mem_data(mem_data),
        .new_read_valid(new_read_valid), .new_ctx(new_ctx), .load_done(load_done),
        .new_read(new_read), .status_out(status_out), .ctx_out(ctx_out),
        .query_out(query_out), .mem_out(mem_out),
        .ctx_count(ctx_count), .mem_count(mem_count),
        .ctx_overflow(ctx_overflow), .mem_overflow(mem_overflow), .done(done)
    );

    always #5 Clk_32UI = ~Clk_32UI;

    // Query RAM model: byte at address a is a, returned QLAT cycles after the address.
    logic [7:0] qd [QLAT];
    always @(posedge Clk_32UI) begin
        qd[0] <= query_position_2RAM;
        for (int k = 1; k < QLAT; k++) qd[k] <= qd[k-1];
    end
    assign new_read_query_2Queue = qd[QLAT-1];

    typedef struct {
        logic [5:0]       st;
        logic [CTX_W-1:0] ctx;
        logic [7:0]       q;
        logic [MEM_W-1:0] mem;
        int               at;
    } exp_t;
    exp_t exp_q[$];

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int word_idx = 0;

    function automatic logic [CTX_W-1:0] mk(input int tag);
        logic [31:0]  t;
        logic [319:0] w;
        t = 32'(tag) ^ 32'h5A5A_0000;
        w = {10{t}};
        return w[CTX_W-1:0];
    endfunction

    function automatic logic [MEM_W-1:0] mkm(input int tag);
        logic [31:0] t;
        t = 32'hC0DE_0000 + 32'(tag);
        return {24{t}};
    endfunction

    task automatic chk(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    task automatic push_exp(input logic [5:0] st, input logic [CTX_W-1:0] c, input logic [7:0] q,
                            input logic [MEM_W-1:0] m, input int at);
        exp_t e;
        e.st = st; e.ctx = c; e.q = q; e.mem = m; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        in_status = BUBBLE; in_ctx = '0; in_qpos = 8'd0;
        DRAM_get = 1'b0; mem_data = '0;
        new_read_valid = 1'b0; new_ctx = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk_32UI);
    endtask

    // Monitor: an output word is new only if stall was low at the edge that loaded it.
    initial begin
        bit upd;
        bit ok;
        exp_t e;
        forever begin
            @(posedge Clk_32UI);
            cyc++;
            upd = !stall && reset_n;
            #1;
            if (upd && reset_n && status_out != BUBBLE) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_word cyc=%0d st=%h q=%h ctx=%h", cyc, status_out, query_out, ctx_out[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    ok = (status_out === e.st) && (ctx_out === e.ctx) && (query_out === e.q) &&
                         (mem_out === e.mem) && (e.at < 0 || e.at == cyc);
                    if (ok) pass_cnt++;
                    else $display("FAIL word%0d cyc=%0d/%0d st=%h/%h q=%h/%h ctx=%h/%h mem=%h/%h",
                                  word_idx, cyc, e.at, status_out, e.st, query_out, e.q,
                                  ctx_out[63:0], e.ctx[63:0], mem_out[63:0], e.mem[63:0]);
                end
                word_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CTX_W-1:0] c, e;
        int pd;
        reset_n = 1'b0; stall = 1'b0; load_done = 1'b0;
        idle();
        step(3);
        chk("rst_status", 1024'(status_out), 1024'(BUBBLE));
        chk("rst_ctx", 1024'(ctx_out), 1024'({CTX_W{1'b1}}));
        chk("rst_query", 1024'(query_out), 1024'(8'hFF));
        chk("rst_mem", 1024'(mem_out), 1024'({MEM_W{1'b1}}));
        chk("rst_counts", 1024'({ctx_count, mem_count}), 1024'(0));
        chk("rst_flags", 1024'({ctx_overflow, mem_overflow, done, new_read}), 1024'(0));
        reset_n = 1'b1;
        step(2);

        // Fresh read into an empty queue.
        c = mk(1); c[13:7] = 7'd5; c[6:0] = 7'd40;
        e = c;     e[13:7] = 7'd6; e[6:0] = 7'd1;
        new_ctx = c; new_read_valid = 1'b1;
        push_exp(6'd0, e, 8'd0, {MEM_W{1'b1}}, cyc + 1);
        #1 chk("t1_new_read_hi", 1024'(new_read), 1024'(1));
        step(1);
        idle();
        #1 chk("t1_new_read_lo", 1024'(new_read), 1024'(0));
        step(2);

        // F_run word paired with a response one cycle later.
        in_status = 6'd1; in_ctx = mk(2); in_qpos = 8'h02;
        push_exp(6'd1, mk(2), 8'h02, mkm(2), cyc + 5);
        step(1);
        idle(); DRAM_get = 1'b1; mem_data = mkm(2);
        step(1);
        idle();
        chk("t2_mem_cnt1", 1024'(mem_count), 1024'(1));
        step(2);
        chk("t2_ctx_cnt1", 1024'(ctx_count), 1024'(1));
        step(1);
        chk("t2_counts0", 1024'({ctx_count, mem_count}), 1024'(0));
        step(2);

        // F_break head bypasses a waiting response.
        DRAM_get = 1'b1; mem_data = mkm(3);
        step(1);
        idle();
        step(1);
        in_status = 6'd2; in_ctx = mk(3); in_qpos = 8'h03;
        push_exp(6'd2, mk(3), 8'h03, {MEM_W{1'b1}}, cyc + 5);
        step(1);
        idle();
        step(6);
        chk("t3_mem_cnt", 1024'(mem_count), 1024'(1));
        chk("t3_ctx_cnt", 1024'(ctx_count), 1024'(0));

        // Fill to capacity under stall, then one more to overflow.
        stall = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_status = 6'd2; in_ctx = mk(100 + i); in_qpos = 8'(i);
            push_exp(6'd2, mk(100 + i), 8'(i), {MEM_W{1'b1}}, -1);
            step(1);
        end
        idle();
        step(5);
        chk("t4_full_cnt", 1024'(ctx_count), 1024'(256));
        chk("t4_no_ovf_yet", 1024'(ctx_overflow), 1024'(0));
        chk("t4_hold", 1024'(status_out), 1024'(BUBBLE));
        in_status = 6'd2; in_ctx = mk(999); in_qpos = 8'hEE;
        step(1);
        idle();
        step(5);
        chk("t4_full_cnt2", 1024'(ctx_count), 1024'(256));
        chk("t4_ovf", 1024'(ctx_overflow), 1024'(1));
        chk("t4_mem_ovf", 1024'(mem_overflow), 1024'(0));
        stall = 1'b0;
        step(262);
        chk("t4_drained", 1024'(ctx_count), 1024'(0));
        chk("t4_ovf_sticky", 1024'(ctx_overflow), 1024'(1));
        chk("t4_sb_empty", 1024'(exp_q.size()), 1024'(0));

        // Stall holds outputs but not pushes; async reset clears everything.
        c = mk(5); c[13:7] = 7'd20; c[6:0] = 7'd0;
        e = c;     e[13:7] = 7'd21; e[6:0] = 7'd1;
        new_ctx = c; new_read_valid = 1'b1;
        push_exp(6'd0, e, 8'd0, {MEM_W{1'b1}}, cyc + 1);
        step(1);
        idle(); stall = 1'b1;
        step(2);
        chk("t5_hold_init", 1024'(status_out), 1024'(0));
        in_status = 6'd1; in_ctx = mk(5); in_qpos = 8'h05;
        step(1);
        idle();
        step(5);
        chk("t5_stall_push", 1024'(ctx_count), 1024'(1));
        in_status = 6'd1; in_ctx = mk(6); in_qpos = 8'h06;
        step(1);
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_status", 1024'(status_out), 1024'(BUBBLE));
        chk("t5_rst_ctx", 1024'(ctx_out), 1024'({CTX_W{1'b1}}));
        chk("t5_rst_counts", 1024'({ctx_count, mem_count}), 1024'(0));
        chk("t5_rst_ovf", 1024'(ctx_overflow), 1024'(0));
        step(2);
        stall = 1'b0; reset_n = 1'b1;
        step(6);
        chk("t5_pipe_flushed", 1024'(ctx_count), 1024'(0));

        // Drain to done after load_done.
        c = mk(7); c[13:7] = 7'd9; c[6:0] = 7'd3;
        e = c;     e[13:7] = 7'd10; e[6:0] = 7'd1;
        new_ctx = c; new_read_valid = 1'b1;
        push_exp(6'd0, e, 8'd0, {MEM_W{1'b1}}, cyc + 1);
        step(1);
        idle(); load_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_status = 6'd1; in_ctx = mk(60 + i); in_qpos = 8'(10 + i);
            DRAM_get = 1'b1; mem_data = mkm(60 + i);
            push_exp(6'd1, mk(60 + i), 8'(10 + i), mkm(60 + i), cyc + 5);
            pd = cyc + 1;
            step(1);
        end
        idle(); new_read_valid = 1'b1;
        #1 chk("t6_no_new_read", 1024'(new_read), 1024'(0));
        step(1);
        idle();
        while (cyc < pd + 4) step(1);
        chk("t6_done_lo", 1024'(done), 1024'(0));
        step(1);
        chk("t6_done_hi", 1024'(done), 1024'(1));
        step(3);
        chk("t6_done_stays", 1024'(done), 1024'(1));
        chk("t6_counts0", 1024'({ctx_count, mem_count}), 1024'(0));
        chk("t6_sb_empty", 1024'(exp_q.size()), 1024'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/smem_recirc_queue.md
Name: smem_recirc_queue

Overview:
Parametrised successor of the forward-pipeline recirculation queue in the SMEM engine.
- Holds in-flight read contexts in a circular context FIFO and DRAM occupancy responses in a separate memory FIFO.
- Pairs each context head with its memory response, passes F_break entries without a response, and injects fresh reads into idle slots.
- Sits between the forward pipeline output and input. Adds occupancy/overflow reporting, a stall-safe write path and a drain/done FSM.

Parameters:
CTX_W, 290, context payload width (ptr_curr, read_num, ik_x0..ik_info, forward_i, min_intv).
DEPTH, 256, context FIFO entries (power of two).
MEM_W, 768, memory response width (cnt_a*, cnt_b*, cntl_a*, cntl_b* concatenated).
MEM_DEPTH, 32, memory FIFO entries (power of two).
QLAT, 3, query RAM read latency in cycles (>=1).

Ports:
Clk_32UI  in  1  clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  freezes the output pops and the new-read injection only
in_status  in  6  status of the pipeline word entering the queue
in_ctx  in  CTX_W  context of the entering word
query_position_2RAM  out  8  query address, combinational copy of in_qpos
in_qpos  in  8  next query position
new_read_query_2Queue  in  8  query byte, valid QLAT cycles after its address
DRAM_get  in  1  memory response strobe
mem_data  in  MEM_W  memory response payload
new_read_valid  in  1  a fresh read is presented on new_ctx
new_ctx  in  CTX_W  fresh read context
load_done  in  1  no further fresh reads will be offered once new_read_valid falls
new_read  out  1  fresh read consumed this cycle
status_out  out  6  output status
ctx_out  out  CTX_W  output context
query_out  out  8  output query byte
mem_out  out  MEM_W  output memory response
ctx_count  out  $clog2(DEPTH)+1  context FIFO occupancy
mem_count  out  $clog2(MEM_DEPTH)+1  memory FIFO occupancy
ctx_overflow  out  1  sticky, a context push was dropped
mem_overflow  out  1  sticky, a memory push was dropped
done  out  1  queue fully drained

Behaviour:
Status codes: F_init=0, F_run=1, F_break=2, BUBBLE=6'h30.
- A word is queue-valid iff its status is in {0,1,2}.

Reset (asynchronous, all outputs):
- FIFO pointers, counts and both overflow flags = 0.
- status_out=BUBBLE; ctx_out, query_out and mem_out all-ones.
- new_read=0, done=0, FSM=FILL.
- Reset mid-operation discards every entry, including words in the delay pipe.

Delay pipe and context push:
- Delay pipe: QLAT register stages carry {in_status, in_ctx}. It advances every cycle and ignores stall.
- At pipe exit the word is joined with new_read_query_2Queue. A queue-valid word is pushed into the context FIFO on the next edge, independent of stall.
- Push when full (ctx_count==DEPTH with no pop that cycle): entry dropped, ctx_overflow set.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.

Memory FIFO push:
- DRAM_get pushes mem_data into the memory FIFO, independent of stall.
- Push when full with no pop that cycle: response dropped, mem_overflow set.

Output selection (registered, evaluated only when stall=0; outputs hold while stall=1):
Priority order, first match wins:
1. Context head has status F_break: pop the context only; mem_out all-ones.
2. Context FIFO is non-empty and memory FIFO is non-empty: pop both; emit the head with its response.
3. FSM is not DRAIN and new_read_valid=1:
   - status_out=F_init; ctx_out=new_ctx with the forward_i field +1, min_intv field=1.
   - query_out=0; new_read=1 (combinational, this cycle).
4. Otherwise: emit BUBBLE with all-ones payloads.
- A head with status F_init/F_run and an empty memory FIFO blocks rule 2. Rule 3 or 4 applies instead; the head is never skipped.
- Pointers wrap modulo depth. Counts are exact.

Latency:
- A word entering at cycle t becomes FIFO-visible at t+QLAT+1.
- It can appear on the outputs at t+QLAT+2.

FSM:
- FILL -> RUN on the first new_read.
- RUN -> DRAIN when load_done=1 and new_read_valid=0.
- DRAIN -> DONE when the delay pipe holds no valid word and both counts are 0.
- done=1 only in DONE. DONE is left only by reset.
- In DRAIN, new_read is forced to 0.

Test Plan:
1. Inject new_read_valid with forward_i=5, memory FIFO empty -> status_out=0, forward_i field=6, min_intv field=1, query_out=0, new_read=1 for one cycle.
2. Feed in_status=1 with query byte 0x2 at QLAT=3 and DRAM_get one cycle later -> that entry emitted at t+5 with query_out=0x2 and mem_out=mem_data; both counts return to 0.
3. Head in_status=2 with memory FIFO holding one response -> head popped with mem_out all-ones; mem_count stays 1.
4. Push 257 queue-valid words with stall=1 throughout -> ctx_count=256, ctx_overflow=1, no outputs change; release stall -> entries 0..255 emerge in order.
5. Assert stall while a word is in the delay pipe -> the word is still stored (ctx_count increments); assert reset_n=0 asynchronously mid-cycle -> status_out=BUBBLE and ctx_count=0 immediately.
6. load_done=1, new_read_valid=0, then drain 3 entries with matching responses -> done rises the cycle after the last pop; new_read stays 0.
